// File: rtl/pulse_sequencer.sv
// pulse_sequencer
// ---------------
// Programmable pulse-train controller. A host loads one configuration
// (delay, high time, low time, pulse count). The block then walks an
// internal phase counter through DELAY -> HIGH -> (LOW -> HIGH)* -> DONE
// and drives pulse_out high during every HIGH phase.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   cfg_valid    host presents a configuration
//   cfg_ready    block can accept a configuration (state IDLE)
//   cfg_delay    cycles before the first pulse (0 skips DELAY)
//   cfg_high     pulse high time in cycles (0 treated as 1)
//   cfg_low      gap between pulses in cycles (0 treated as 1)
//   cfg_repeat   pulses in the burst (0 treated as 1)
//   abort        terminate the running burst
//   busy         burst in progress (state != IDLE)
//   pulse_out    generated pulse train (state == HIGH)
//   done         one-cycle strobe on normal completion (state == DONE)
//   aborted      one-cycle registered strobe after an abort
//   phase_cnt    cycle index within the current phase
//   pulses_left  pulses not yet finished, including the current one
//   dbg_state    registered FSM state, for observation only
//
// Handshake: a configuration transfers on a rising edge where cfg_valid
// and cfg_ready are both 1. cfg_ready depends only on the registered
// state, never on cfg_valid. While cfg_ready is 0, cfg_valid and the
// cfg_* fields are ignored and the latched configuration is unchanged.
module pulse_sequencer #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WIDTH-1:0]    cfg_delay,
  input  logic [WIDTH-1:0]    cfg_high,
  input  logic [WIDTH-1:0]    cfg_low,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  input  logic                abort,
  output logic                busy,
  output logic                pulse_out,
  output logic                done,
  output logic                aborted,
  output logic [WIDTH-1:0]    phase_cnt,
  output logic [REPEAT_W-1:0] pulses_left,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_phase_cnt;
  logic [REPEAT_W-1:0] r_pulses_left;
  logic [WIDTH-1:0]    r_delay;
  logic [WIDTH-1:0]    r_high;
  logic [WIDTH-1:0]    r_low;
  logic                r_aborted;

  state_t              w_state_nxt;
  logic [WIDTH-1:0]    w_phase_nxt;
  logic [REPEAT_W-1:0] w_pulses_nxt;
  logic                w_aborted_nxt;
  logic                w_load;
  logic [WIDTH-1:0]    w_len_m1;
  logic                w_phase_end;

  // High and low lengths are stored already clamped to at least 1, so the
  // phase-end compare below never needs to special-case zero. The delay is
  // stored raw: a zero delay never enters DELAY, so its length is unused.
  always_comb begin
    w_len_m1 = '0;
    case (r_state)
      S_DELAY: w_len_m1 = r_delay - WIDTH'(1);
      S_HIGH:  w_len_m1 = r_high  - WIDTH'(1);
      S_LOW:   w_len_m1 = r_low   - WIDTH'(1);
      default: w_len_m1 = '0;
    endcase
  end

  assign w_phase_end = (r_phase_cnt == w_len_m1);

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase_cnt;
    w_pulses_nxt  = r_pulses_left;
    w_aborted_nxt = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt  = '0;
        w_pulses_nxt = '0;
        // abort is deliberately not looked at here: a handshake in the
        // same cycle as abort still starts a burst.
        if (cfg_valid) begin
          w_load       = 1'b1;
          w_pulses_nxt = (cfg_repeat == '0) ? REPEAT_W'(1) : cfg_repeat;
          w_state_nxt  = (cfg_delay != '0) ? S_DELAY : S_HIGH;
        end
      end
      S_DELAY, S_HIGH, S_LOW: begin
        if (abort) begin
          w_state_nxt   = S_IDLE;
          w_phase_nxt   = '0;
          w_pulses_nxt  = '0;
          w_aborted_nxt = 1'b1;
        end else if (w_phase_end) begin
          w_phase_nxt = '0;
          if (r_state == S_HIGH) begin
            w_pulses_nxt = r_pulses_left - REPEAT_W'(1);
            // The last pulse goes straight to DONE: no trailing gap.
            w_state_nxt  = (r_pulses_left == REPEAT_W'(1)) ? S_DONE : S_LOW;
          end else begin
            w_state_nxt = S_HIGH;
          end
        end else begin
          w_phase_nxt = r_phase_cnt + WIDTH'(1);
        end
      end
      S_DONE: begin
        // Abort is ignored here; the completed burst stands.
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_phase_nxt  = '0;
        w_pulses_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase_cnt   <= '0;
      r_pulses_left <= '0;
      r_aborted     <= 1'b0;
      r_delay       <= '0;
      r_high        <= '0;
      r_low         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase_cnt   <= w_phase_nxt;
      r_pulses_left <= w_pulses_nxt;
      r_aborted     <= w_aborted_nxt;
      if (w_load) begin
        r_delay <= cfg_delay;
        r_high  <= (cfg_high == '0) ? WIDTH'(1) : cfg_high;
        r_low   <= (cfg_low  == '0) ? WIDTH'(1) : cfg_low;
      end
    end
  end

  assign cfg_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign pulse_out   = (r_state == S_HIGH);
  assign done        = (r_state == S_DONE);
  assign aborted     = r_aborted;
  assign phase_cnt   = r_phase_cnt;
  assign pulses_left = r_pulses_left;
  assign dbg_state   = r_state;

endmodule
